// File: rtl/ps2_host_ctrl.sv
// PS/2 host command sequencer with retry/timeout and an RX scan-code FIFO (first-word fall-through).
// Status pulses and the port send strobe are registered; commands are held off while the port is busy.
module ps2_host_ctrl #(
  parameter int FIFO_DEPTH    = 8,
  parameter int REPLY_TIMEOUT = 20000,
  parameter int MAX_RETRY     = 3,
  parameter int INIT_RESET    = 1
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       ck1us,
  input  logic [7:0] host_cmd_i,
  input  logic       host_cmd_v_i,
  output logic       host_cmd_rdy_o,
  output logic       cmd_done_o,
  output logic       cmd_err_o,
  output logic [7:0] port_cmd_o,
  output logic       port_cmd_v_o,
  input  logic       port_busy_i,
  input  logic       port_acked_i,
  input  logic       port_errd_i,
  input  logic [7:0] port_code_i,
  input  logic       port_code_v_i,
  output logic [7:0] rx_data_o,
  output logic       rx_empty_o,
  input  logic       rx_rd_i,
  output logic       rx_ovf_o,
  input  logic       rx_ovf_clr_i
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = $clog2(REPLY_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WF_TX, WF_REPLY, RETRY} state_e;

  state_e        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          init_q, init_d;
  logic          live_q;
  logic [7:0]    port_cmd_q, port_cmd_d;
  logic          port_v_q, port_v_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic tmo, consume, push_req, push, pop, full, empty, ovf_evt;

  // Expiry is the strobe that takes the timer from 1 to 0 (or any strobe once already at 0).
  assign tmo = ck1us && (timer_q <= TW'(1));

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    init_d     = init_q;
    port_cmd_d = port_cmd_q;
    port_v_d   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    consume    = 1'b0;
    if ((state_q == WF_TX || state_q == WF_REPLY) && ck1us && timer_q != '0)
      timer_d = timer_q - TW'(1);
    case (state_q)
      IDLE: begin
        if (init_q) begin
          cmd_d   = 8'hFF;
          retry_d = '0;
          init_d  = 1'b0;
          state_d = ISSUE;
        end else if (host_cmd_v_i && host_cmd_rdy_o) begin
          cmd_d   = host_cmd_i;
          retry_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!port_busy_i) begin
          port_v_d   = 1'b1;
          port_cmd_d = cmd_q;
          timer_d    = TW'(REPLY_TIMEOUT);
          state_d    = WF_TX;
        end
      end
      WF_TX: begin
        if (port_acked_i) begin
          timer_d = TW'(REPLY_TIMEOUT);
          state_d = WF_REPLY;
        end else if (port_errd_i || tmo) begin
          state_d = RETRY;
        end
      end
      WF_REPLY: begin
        // Any arriving byte beats a same-cycle expiry; ordinary bytes keep waiting.
        if (port_code_v_i && port_code_i == 8'hFA) begin
          consume = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (port_code_v_i && port_code_i == 8'hFE) begin
          consume = 1'b1;
          state_d = RETRY;
        end else if (!port_code_v_i && tmo) begin
          state_d = RETRY;
        end
      end
      RETRY: begin
        if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          state_d = ISSUE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_req = port_code_v_i && !consume;
  assign pop      = rx_rd_i && !empty;
  assign push     = push_req && (!full || pop);
  assign ovf_evt  = push_req && !push;
  assign wr_d     = push ? wr_q + 1'b1 : wr_q;
  assign rd_d     = pop ? rd_q + 1'b1 : rd_q;
  assign ovf_d    = ovf_evt || (ovf_q && !rx_ovf_clr_i);

  always_ff @(posedge clk6x or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cmd_q      <= 8'h00;
      retry_q    <= '0;
      timer_q    <= '0;
      init_q     <= (INIT_RESET != 0);
      live_q     <= 1'b0;
      port_cmd_q <= 8'h00;
      port_v_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      init_q     <= init_d;
      live_q     <= 1'b1;
      port_cmd_q <= port_cmd_d;
      port_v_q   <= port_v_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk6x) begin
    if (push) mem_q[wr_q[AW-1:0]] <= port_code_i;
  end

  assign host_cmd_rdy_o = live_q && (state_q == IDLE) && !init_q && !port_busy_i;
  assign cmd_done_o     = done_q;
  assign cmd_err_o      = err_q;
  assign port_cmd_o     = port_cmd_q;
  assign port_cmd_v_o   = port_v_q;
  assign rx_empty_o     = empty;
  assign rx_data_o      = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
  assign rx_ovf_o       = ovf_q;

endmodule

// File: doc/ps2_host_ctrl.md
PS2_HOST_CTRL -- requirements
Module: ps2_host_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, meaning RX scan-code FIFO entries (power of two, 2..64).
REQ-002 Parameter REPLY_TIMEOUT, default 20000, meaning microseconds allowed per wait phase before retry.
REQ-003 Parameter MAX_RETRY, default 3, meaning re-sends after first attempt before failure.
REQ-004 Parameter INIT_RESET, default 1, meaning 1 = auto-send 0xFF (device reset) after reset release.
REQ-005 clk6x  in  1  48 MHz system clock; one clock, all state on posedge clk6x.
REQ-006 resetn  in  1  reset, asynchronous and active-low.
REQ-007 ck1us  in  1  1 us strobe, 1 clk6x cycle wide.
REQ-008 host_cmd_i  in  8  command byte from host register.
REQ-009 host_cmd_v_i  in  1  command request; accepted in the cycle host_cmd_rdy_o=1.
REQ-010 host_cmd_rdy_o  out  1  controller idle, no init pending, and port_busy_i=0.
REQ-011 cmd_done_o  out  1  1-cycle pulse, command acknowledged (0xFA received).
REQ-012 cmd_err_o  out  1  1-cycle pulse, command abandoned after retries.
REQ-013 port_cmd_o  out  8  byte to PS2 port TX.
REQ-014 port_cmd_v_o  out  1  1-cycle send strobe to PS2 port.
REQ-015 port_busy_i, port_acked_i, port_errd_i  in  1 each  PS2 port busy level, TX line-ACK pulse, TX NACK pulse.
REQ-016 port_code_i  in  8 / port_code_v_i  in  1  byte received from device, valid pulse.
REQ-017 rx_data_o  out  8  FIFO head (first-word fall-through); rx_empty_o  out  1; rx_rd_i  in  1  pop.
REQ-018 rx_ovf_o  out  1  sticky overflow flag; rx_ovf_clr_i  in  1  clears it.

Function
REQ-019 FSM states: IDLE, ISSUE, WF_TX, WF_REPLY, RETRY.
REQ-020 IDLE: init_pending (set by reset when INIT_RESET=1) wins over host; selects 0xFF, clears init_pending, -> ISSUE.
REQ-021 IDLE: host_cmd_v_i with host_cmd_rdy_o=1 latches host_cmd_i into cmd register, retry_cnt=0, -> ISSUE.
REQ-022 ISSUE: when port_busy_i=0, port_cmd_v_o=1 for exactly one cycle with port_cmd_o=cmd, timer loaded with REPLY_TIMEOUT, -> WF_TX; else stay.
REQ-023 WF_TX: port_acked_i -> WF_REPLY with timer reloaded; port_errd_i or timer expiry -> RETRY.
REQ-024 WF_REPLY: port_code_v_i with 0xFA -> cmd_done_o pulse, -> IDLE, byte not queued; 0xFE -> RETRY, byte not queued; other byte queued to FIFO, stay; timer expiry -> RETRY.
REQ-025 RETRY: retry_cnt<MAX_RETRY -> retry_cnt+1, -> ISSUE; else cmd_err_o pulse, -> IDLE.
REQ-026 Timer decrements on ck1us only in WF_TX/WF_REPLY; expiry is reaching 0; reply arriving in expiry cycle takes priority.
REQ-027 In every state except WF_REPLY's 0xFA/0xFE consumption, port_code_v_i pushes port_code_i into FIFO.
REQ-028 FIFO push when full: byte dropped, rx_ovf_o set; simultaneous push and pop when full: both performed, no overflow.
REQ-029 Pop when empty ignored; rx_data_o valid whenever rx_empty_o=0; rx_ovf_clr_i and overflow in same cycle: flag stays 1.
REQ-030 host_cmd_v_i outside IDLE ignored (not queued); cmd_done_o and cmd_err_o never both high.

Reset
REQ-031 resetn low, asynchronously: state=IDLE, FIFO empty (rx_empty_o=1), rx_data_o=0x00, rx_ovf_o=0, all pulses 0, port_cmd_o=0x00, host_cmd_rdy_o=0, retry_cnt=0, timer=0, init_pending=INIT_RESET.
REQ-032 Reset asserted mid-command: command discarded, no cmd_done_o/cmd_err_o generated after release.

Verification
REQ-033 Release reset, INIT_RESET=1, port idle -> port_cmd_v_o with 0xFF; acked, reply 0xFA then 0xAA -> cmd_done_o, FIFO holds only 0xAA.
REQ-034 Host 0xF4, device replies 0xFE twice then 0xFA -> three port_cmd_v_o strobes of 0xF4, one cmd_done_o.
REQ-035 Host 0xED, no reply, MAX_RETRY=3 -> four strobes spaced by 20000 us timeouts, then cmd_err_o, back to IDLE.
REQ-036 Push 9 bytes 0x01..0x09 without pop (depth 8) -> rx_ovf_o=1, pops return 0x01..0x08; push+pop at full -> no overflow.
REQ-037 Scan code 0x1C arrives in WF_REPLY before 0xFA -> 0x1C queued, command completes with cmd_done_o.
REQ-038 resetn pulsed low during WF_REPLY -> outputs at reset values immediately, no completion pulse.
